// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, controller states and the access legality rule shared by the LSU.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_LD_RD, S_RMW_RD, S_WR, S_RESP} state_e;

    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic bad_f3, mis;
        bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && (f3 == F3_BU || f3 == F3_HU));
        mis    = ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
        return bad_f3 || mis;
    endfunction
endpackage

// File: rtl/data_mem_lsu_lane.sv
// lsu_lane: byte/half lane extraction with sign/zero extension, and store merge into an old word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;

    always_comb begin
        sh      = funct3[0] ? {addr[1], 4'b0} : {addr, 3'b0};
        b       = word[{addr, 3'b0} +: 8];
        h       = word[{addr[1], 4'b0} +: 16];
        ld_data = funct3 == F3_W ? word :
                  funct3[0] ? {{16{!funct3[2] && h[15]}}, h} : {{24{!funct3[2] && b[7]}}, b};
        mask    = (funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        st_word = funct3 == F3_W ? wdata : (word & ~mask) | ((wdata << sh) & mask);
    end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32I load/store controller for a word-only RAM; SB/SH use read-modify-write.
module data_mem_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    state_e      state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] ld_data, st_word;

    lsu_lane u_lane (
        .addr    (addr_q),
        .funct3  (f3_q),
        .word    (mem_rdata),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                addr_d      = req_addr[1:0];
                f3_d        = req_funct3;
                wdata_d     = req_wdata;
                mem_addr_d  = {req_addr[31:2], 2'b00};
                mem_wdata_d = req_wdata;
                rdata_d     = '0;
                err_d       = access_err(req_we, req_funct3, req_addr[1:0]);
                state_d     = err_d ? S_RESP : !req_we ? S_LD_RD : req_funct3 == F3_W ? S_WR : S_RMW_RD;
            end
            S_LD_RD: begin
                rdata_d = ld_data;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                mem_wdata_d = st_word;
                state_d     = S_WR;
            end
            S_WR: state_d = S_RESP;
            default: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            f3_q        <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Reset wins over a pending write so an abandoned RMW never reaches the RAM.
    assign mem_we    = state_q == S_WR && !rst;
    assign req_ready = state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed table, reset corner case, streaming and random checks against a byte-level model.
module tb_data_mem_lsu;
    import lsu_pkg::*;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, req_we = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        rsp_valid, rsp_err, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    data_mem_lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] ram [0:1023];
    logic [7:0]  rb  [0:4095];
    int          wr_cnt = 0;
    logic [31:0] last_wa = 0, last_wd = 0;

    assign mem_rdata = ram[mem_addr[11:2]];

    always @(posedge clk) if (mem_we) begin
        ram[mem_addr[11:2]] <= mem_wdata;
        wr_cnt  <= wr_cnt + 1;
        last_wa <= mem_addr;
        last_wd <= mem_wdata;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] wd;
    } vec_t;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    endtask

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        ram[a[11:2]] = w;
        for (int i = 0; i < 4; i++) rb[{a[11:2], 2'b00} + i] = w[8*i +: 8];
    endtask

    // Reference: byte-addressed memory, access size from funct3, legality from the RV32I rules.
    task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int nwr, output int lat);
        int size, base;
        logic legal;
        logic [31:0] v;
        size  = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) && !(we && f3[2]);
        base  = int'(a[11:0]);
        rd = 0; nwr = 0;
        err = !legal || (base % size) != 0;
        lat = err ? 1 : (we && size < 4) ? 3 : 2;
        if (!err && we) begin
            for (int i = 0; i < size; i++) rb[base + i] = wd[8*i +: 8];
            nwr = 1;
        end else if (!err) begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (32'(rb[base + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endtask

    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        rd = rsp_rdata; er = rsp_err;
    endtask

    vec_t tv[14];
    vec_t sq[4];

    task automatic present(input int i);
        req_we = sq[i].we; req_funct3 = sq[i].f3; req_addr = sq[i].addr; req_wdata = sq[i].wdata;
    endtask

    initial begin
        logic [31:0] rd, mrd, erd[4];
        logic er, merr, seen, eer[4];
        int lat, mlat, mnwr, w0, idx, got, acc, bad_ready;
        bit pend;

        for (int i = 0; i < 1024; i++) put_word(32'(i * 4), $urandom);

        repeat (3) @(negedge clk);
        chk("reset mem_we", {31'b0, mem_we}, 0);
        rst = 0;
        @(negedge clk);
        chk("reset req_ready", {31'b0, req_ready}, 1);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset rsp_err", {31'b0, rsp_err}, 0);
        chk("reset mem_we idle", {31'b0, mem_we}, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);

        // Reset held across the write cycle of an SB must cancel the write and the response.
        put_word(32'h300, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = F3_B; req_addr = 32'h301; req_wdata = 32'hEE;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("midreset in WR", {31'b0, mem_we}, 1);
        w0 = wr_cnt; rst = 1; seen = 0;
        repeat (3) begin @(negedge clk); seen = seen | rsp_valid | mem_we; end
        rst = 0;
        repeat (3) begin @(negedge clk); seen = seen | rsp_valid | mem_we; end
        chk("midreset writes", 32'(wr_cnt - w0), 0);
        chk("midreset no pulse", {31'b0, seen}, 0);
        chk("midreset ram kept", ram[32'h300 >> 2], 32'h1122_3344);
        chk("midreset ready", {31'b0, req_ready}, 1);

        put_word(32'h100, 32'h8899_AABB);
        tv[0]  = '{0, F3_B,   32'h101, 32'h0,         32'hFFFF_FFAA, 0, 2, 0, 32'h0};
        tv[1]  = '{0, F3_BU,  32'h103, 32'h0,         32'h0000_0088, 0, 2, 0, 32'h0};
        tv[2]  = '{0, F3_H,   32'h102, 32'h0,         32'hFFFF_8899, 0, 2, 0, 32'h0};
        tv[3]  = '{0, F3_HU,  32'h100, 32'h0,         32'h0000_AABB, 0, 2, 0, 32'h0};
        tv[4]  = '{1, F3_B,   32'h102, 32'h1234_5677, 32'h0,         0, 3, 1, 32'h8877_AABB};
        tv[5]  = '{0, F3_W,   32'h100, 32'h0,         32'h8877_AABB, 0, 2, 0, 32'h0};
        tv[6]  = '{1, F3_W,   32'h200, 32'hDEAD_BEEF, 32'h0,         0, 2, 1, 32'hDEAD_BEEF};
        tv[7]  = '{0, F3_W,   32'h200, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 32'h0};
        tv[8]  = '{1, F3_H,   32'h202, 32'h0000_CAFE, 32'h0,         0, 3, 1, 32'hCAFE_BEEF};
        tv[9]  = '{0, F3_W,   32'h200, 32'h0,         32'hCAFE_BEEF, 0, 2, 0, 32'h0};
        tv[10] = '{0, F3_W,   32'h201, 32'h0,         32'h0,         1, 1, 0, 32'h0};
        tv[11] = '{0, F3_H,   32'h103, 32'h0,         32'h0,         1, 1, 0, 32'h0};
        tv[12] = '{0, 3'b011, 32'h100, 32'h0,         32'h0,         1, 1, 0, 32'h0};
        tv[13] = '{1, F3_BU,  32'h100, 32'h55,        32'h0,         1, 1, 0, 32'h0};
        foreach (tv[i]) begin
            w0 = wr_cnt;
            xfer(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, rd, er, lat);
            ref_op(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, mrd, merr, mnwr, mlat);
            chk($sformatf("vec%0d rdata", i), rd, tv[i].rd);
            chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, tv[i].err});
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tv[i].lat));
            chk($sformatf("vec%0d writes", i), 32'(wr_cnt - w0), 32'(tv[i].nwr));
            if (tv[i].nwr != 0) begin
                chk($sformatf("vec%0d mem_wdata", i), last_wd, tv[i].wd);
                chk($sformatf("vec%0d mem_addr", i), last_wa, tv[i].addr & 32'hFFFF_FFFC);
            end
        end

        // Continuous req_valid: each request must be taken exactly once, responses in order.
        sq[0] = '{1, F3_W,  32'h400, 32'h1357_9BDF, 0, 0, 0, 0, 0};
        sq[1] = '{0, F3_W,  32'h400, 32'h0,         0, 0, 0, 0, 0};
        sq[2] = '{1, F3_B,  32'h401, 32'h0000_00A5, 0, 0, 0, 0, 0};
        sq[3] = '{0, F3_H,  32'h400, 32'h0,         0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) ref_op(sq[i].we, sq[i].f3, sq[i].addr, sq[i].wdata, erd[i], eer[i], mnwr, mlat);
        @(negedge clk);
        present(0); req_valid = 1;
        idx = 0; got = 0; acc = 0; pend = 0; bad_ready = 0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            if (pend) begin
                idx++; pend = 0;
                if (idx < 4) present(idx); else req_valid = 0;
            end
            if (rsp_valid) begin
                if (req_ready) bad_ready++;
                chk($sformatf("stream%0d rdata", got), rsp_rdata, erd[got]);
                chk($sformatf("stream%0d err", got), {31'b0, rsp_err}, {31'b0, eer[got]});
                got++;
            end
            if (req_valid && req_ready) begin acc++; pend = 1; end
            @(negedge clk);
        end
        req_valid = 0;
        chk("stream responses", 32'(got), 4);
        chk("stream accepts", 32'(acc), 4);
        chk("stream ready in resp", 32'(bad_ready), 0);

        for (int i = 0; i < 300; i++) begin
            logic we_r;
            logic [2:0] f3_r;
            logic [31:0] a_r, wd_r;
            we_r = 1'($urandom); f3_r = 3'($urandom);
            a_r = 32'($urandom_range(0, 4095)); wd_r = $urandom;
            w0 = wr_cnt;
            xfer(we_r, f3_r, a_r, wd_r, rd, er, lat);
            ref_op(we_r, f3_r, a_r, wd_r, mrd, merr, mnwr, mlat);
            chk($sformatf("rand%0d rdata", i), rd, mrd);
            chk($sformatf("rand%0d err", i), {31'b0, er}, {31'b0, merr});
            chk($sformatf("rand%0d latency", i), 32'(lat), 32'(mlat));
            chk($sformatf("rand%0d writes", i), 32'(wr_cnt - w0), 32'(mnwr));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store initiator driving the word-only data RAM port (`mem_we`/`mem_addr`/`mem_wdata`/`mem_rdata`, combinational read, write on `posedge clk`) on behalf of the RV32I core's MEM stage. Accepts one load or store at a time via a valid/ready handshake and handles byte/halfword lane selection and sign/zero extension. Implements SB/SH as read-modify-write, because the RAM has no byte enables. Reports misaligned or illegal accesses as errors without touching memory.

## Interface
- No parameters; data/address width fixed at 32.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: controller idle; a request transfers when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle completion pulse; no back-pressure.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: valid with `rsp_valid`; misaligned or illegal funct3.
- `mem_we` out 1: RAM write strobe.
- `mem_addr` out 32: word-aligned RAM address, {addr[31:2], 2'b00}.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: RAM combinational read data for `mem_addr`.

## Operation
- States: IDLE, LD_RD, RMW_RD, WR, RESP.
- IDLE: `req_ready`=1. On transfer, latch addr, funct3, we, wdata, then check legality:
  - Illegal: funct3 ∈ {011,110,111}, or store with 100/101.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
  - Illegal or misaligned: set err flag → RESP (no RAM access).
  - Load → LD_RD. SW → WR with merge word = wdata. SB/SH → RMW_RD.
- LD_RD: capture `mem_rdata`. Select lane by addr[1:0] (byte) or addr[1] (half). Sign-extend for B/H, zero-extend for BU/HU → RESP.
- RMW_RD: capture `mem_rdata`. Replace the byte at addr[1:0] or the half at addr[1] with wdata[7:0]/[15:0]. Other lanes are preserved → WR.
- WR: `mem_we`=1 for exactly this cycle, `mem_wdata`=merge word → RESP.
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_err` valid, `req_ready`=0 → IDLE.
- `req_valid` outside IDLE is ignored; the core must hold the request until `req_ready`.
- `mem_we` = (state==WR) && !rst, so reset asserted during WR suppresses the write.
- Little-endian: byte lane n = bits [8n+7:8n].

## Timing
- Request accepted at edge T:
  - Loads: `rsp_valid` high in cycle T+2.
  - SW: write at edge ending cycle T+1, `rsp_valid` in T+2.
  - SB/SH: read in T+1, write in T+2, `rsp_valid` in T+3.
  - Error: `rsp_valid` with `rsp_err`=1 in T+1.
- Throughput: one request per 3 (LW/SW), 4 (SB/SH) or 2 (error) cycles. Next request is accepted no earlier than the cycle after RESP.
- Back-to-back: a store followed by a load to the same word returns the stored data, since the write commits before RESP.
- `mem_addr` is registered from the latched address and stable from T+1 through RESP. `mem_wdata` is registered and stable during WR.
- Reset values: state IDLE, `req_ready`=1 (combinational from IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation: abandons the access with no write and no response; IDLE next cycle.

## Structure
- Shared package `lsu_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding.
- Sub-module `lsu_lane`: combinational.
  - Load extract/extend: addr[1:0], funct3, word → data.
  - Store merge: addr[1:0], funct3, old word, wdata → new word.
- Top holds the FSM and registers only.

## Test plan
- Reset, then check outputs: `req_ready`=1, all other outputs 0; assert `rst` for 3 cycles mid-SB in WR → no `mem_we` pulse, no `rsp_valid`.
- RAM word 0x100 = 0x8899AABB, LB @0x101 → `rsp_rdata`=0xFFFFFFAA at T+2. Same data, LBU @0x103 → 0x00000088. LH @0x102 → 0xFFFF8899. LHU @0x100 → 0x0000AABB.
- SB wdata=0x12345677 @0x102 over 0x8899AABB → one `mem_we` at T+2 with `mem_wdata`=0x8877AABB, `mem_addr`=0x100; `rsp_valid` at T+3, `rsp_err`=0.
- SW 0xDEADBEEF @0x200, then LW @0x200 → 0xDEADBEEF; SH 0xCAFE @0x202, then LW → 0xCAFEBEEF.
- LW @0x201, LH @0x103, funct3=011, store with funct3=100 → each gives `rsp_err`=1 at T+1, `rsp_rdata`=0, no `mem_we`.
- Hold `req_valid` continuously with a stream of 4 requests → `req_ready` only in IDLE, each accepted exactly once, responses in order.
